arp_tx: RTL and testbench

ARP_TX -- requirements
Module: arp_tx

---
 rtl/eth_pkg.sv | 22 ++
 rtl/crc32_d8.sv | 21 ++
 rtl/arp_tx.sv | 161 ++++++++++++++++
 tb/tb_arp_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and the ARP transmitter state type.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;

  // Minimum Ethernet frame without FCS, and the FCS length.
  localparam int MIN_FRAME_LEN = 60;
  localparam int FCS_LEN       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } arp_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide step of the reflected Ethernet CRC-32 (poly 04C11DB7).
// Compiled only when ARP_TX_FCS_EN is defined.
`ifdef ARP_TX_FCS_EN
module crc32_d8 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  // Eight LSB-first shift/xor steps of the reflected register.
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    crc_out = c;
  end

endmodule
`endif

// File: rtl/arp_tx.sv
// ARP reply/request frame generator with an AXI-Stream byte output.
// Replies have priority over pending requests. Define ARP_TX_FCS_EN to
// append a 4-byte CRC-32 FCS (64-byte frame); otherwise 60 bytes are sent.
module arp_tx
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0001
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [47:0] mac_d_addr_in,
  input  logic [31:0] ip_d_addr_in,
  input  logic [31:0] rq_ip_addr,
  input  logic        arp_resp_start,
  input  logic        arp_rq_start,
  output logic        arp_resp_end,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

`ifdef ARP_TX_FCS_EN
  localparam int FRAME_LEN = MIN_FRAME_LEN + FCS_LEN;
`else
  localparam int FRAME_LEN = MIN_FRAME_LEN;
`endif
  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

  arp_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        rq_pend_q, rq_pend_d;
  logic        is_req_q, is_req_d;
  logic [47:0] mac_q, mac_d;
  logic [31:0] ip_q, ip_d;
  logic [31:0] rq_ip_q, rq_ip_d;

  logic        beat;
  logic [47:0] da, tha;
  logic [15:0] oper;
  logic [31:0] tpa;
  logic [479:0] frame_v, frame_sh;

  assign beat = m_axis_tvalid & m_axis_tready;

  // Assemble the 60-byte frame MSB-first and shift the current byte to the top.
  always_comb begin
    da       = is_req_q ? 48'hFFFF_FFFF_FFFF : mac_q;
    tha      = is_req_q ? 48'h0 : mac_q;
    oper     = is_req_q ? ARP_OPER_REQ : ARP_OPER_REPLY;
    tpa      = is_req_q ? rq_ip_q : ip_q;
    frame_v  = {da, LOCAL_MAC, ETHERTYPE_ARP, ARP_HTYPE_ETH, ARP_PTYPE_IPV4,
                ARP_HLEN, ARP_PLEN, oper, LOCAL_MAC, LOCAL_IP, tha, tpa, 144'h0};
    frame_sh = frame_v << {cnt_q, 3'b000};
  end

`ifdef ARP_TX_FCS_EN
  logic [31:0] crc_q, crc_d, crc_next, fcs, fcs_sh;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (m_axis_tdata),
    .crc_out (crc_next)
  );

  assign fcs    = ~crc_q;
  assign fcs_sh = fcs >> {cnt_q[1:0], 3'b000};

  // Accumulate CRC over bytes 0..59; restart it whenever idle.
  always_comb begin
    crc_d = crc_q;
    if (state_q == IDLE) crc_d = 32'hFFFF_FFFF;
    else if (beat && cnt_q < 6'(MIN_FRAME_LEN)) crc_d = crc_next;
  end

  // CRC register.
  always_ff @(posedge aclk) begin
    if (areset) crc_q <= 32'hFFFF_FFFF;
    else        crc_q <= crc_d;
  end
`endif

  // Stream outputs decoded from registered state; zero outside SEND.
  always_comb begin
    m_axis_tvalid = (state_q == SEND);
    m_axis_tlast  = (state_q == SEND) && (cnt_q == LAST_IDX);
    arp_resp_end  = (state_q == DONE);
    m_axis_tdata  = '0;
    if (state_q == SEND) begin
`ifdef ARP_TX_FCS_EN
      if (cnt_q >= 6'(MIN_FRAME_LEN)) m_axis_tdata = fcs_sh[7:0];
      else                            m_axis_tdata = frame_sh[479:472];
`else
      m_axis_tdata = frame_sh[479:472];
`endif
    end
  end

  // Next-state logic: frame selection, address latching, byte counting.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rq_pend_d = rq_pend_q;
    is_req_d  = is_req_q;
    mac_d     = mac_q;
    ip_d      = ip_q;
    rq_ip_d   = rq_ip_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (arp_resp_start || rq_pend_q) begin
          state_d  = SEND;
          is_req_d = !arp_resp_start;
          mac_d    = mac_d_addr_in;
          ip_d     = ip_d_addr_in;
          rq_ip_d  = rq_ip_addr;
          if (!arp_resp_start) rq_pend_d = 1'b0;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = is_req_q ? IDLE : DONE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new request pulse wins over the clear on request-frame entry.
    if (arp_rq_start) rq_pend_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (areset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rq_pend_q <= 1'b0;
      is_req_q  <= 1'b0;
      mac_q     <= '0;
      ip_q      <= '0;
      rq_ip_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rq_pend_q <= rq_pend_d;
      is_req_q  <= is_req_d;
      mac_q     <= mac_d;
      ip_q      <= ip_d;
      rq_ip_q   <= rq_ip_d;
    end
  end

endmodule

// File: tb/tb_arp_tx.sv
// Self-checking bench for arp_tx: directed reply/request/collision/reset
// steps plus randomized frames against a field-level frame model.
// Define ARP_TX_FCS_EN to check the 64-byte FCS variant.
module tb_arp_tx;

  localparam logic [47:0] L_MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] L_IP  = 32'hC0A8_0001;
`ifdef ARP_TX_FCS_EN
  localparam int FLEN = 64;
`else
  localparam int FLEN = 60;
`endif

  logic        aclk;
  logic        areset;
  logic [47:0] mac_d_addr_in;
  logic [31:0] ip_d_addr_in;
  logic [31:0] rq_ip_addr;
  logic        arp_resp_start;
  logic        arp_rq_start;
  logic        arp_resp_end;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  arp_tx dut (
    .aclk           (aclk),
    .areset         (areset),
    .mac_d_addr_in  (mac_d_addr_in),
    .ip_d_addr_in   (ip_d_addr_in),
    .rq_ip_addr     (rq_ip_addr),
    .arp_resp_start (arp_resp_start),
    .arp_rq_start   (arp_rq_start),
    .arp_resp_end   (arp_resp_end),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  logic [7:0] ref_q[$];
  int frames    = 0;
  int resp_ends = 0;
  bit bp_en     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: records accepted beats and checks stream rules.
  int         idx = 0;
  bit         in_frame = 0, stalled = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge aclk) begin
    if (areset) begin
      idx = 0; in_frame = 0; stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", m_axis_tvalid, 1'b1);
        check("stall_data", m_axis_tdata, prev_data);
        check("stall_last", m_axis_tlast, prev_last);
      end else if (in_frame) begin
        check("no_gap", m_axis_tvalid, 1'b1);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        rx.push_back(m_axis_tdata);
        check("tlast_pos", m_axis_tlast, idx == FLEN - 1);
        if (m_axis_tlast) begin idx = 0; in_frame = 0; frames++; end
        else begin idx++; in_frame = 1; end
      end
      stalled   = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      if (arp_resp_end) resp_ends++;
    end
  end

  // One clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
    if (arp_resp_end) arp_resp_start = 1'b0;
    if (bp_en) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames < n; i++) step();
    check("frame_timeout", frames >= n, 1'b1);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic push_field(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask

  // Standard (non-reflected) CRC register fed with each byte LSB-first.
  function automatic logic [31:0] crc_run(input logic [7:0] q[$], input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 8; b++) begin
        logic fb = c[31] ^ q[k][b];
        c = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C1_1DB7;
      end
    return c;
  endfunction

  task automatic build_expected(input bit is_req, input logic [47:0] mac, input logic [31:0] tpa);
    exp_q.delete();
    push_field(is_req ? 48'hFFFF_FFFF_FFFF : mac, 6);
    push_field(L_MAC, 6);
    push_field(48'h0806, 2);
    push_field(48'h0001, 2);
    push_field(48'h0800, 2);
    push_field(48'h06, 1);
    push_field(48'h04, 1);
    push_field(is_req ? 48'h1 : 48'h2, 2);
    push_field(L_MAC, 6);
    push_field({16'h0, L_IP}, 4);
    push_field(is_req ? 48'h0 : mac, 6);
    push_field({16'h0, tpa}, 4);
    for (int i = 0; i < 18; i++) exp_q.push_back(8'h00);
`ifdef ARP_TX_FCS_EN
    begin
      logic [31:0] c, r;
      c = ~crc_run(exp_q, 60);
      for (int b = 0; b < 32; b++) r[b] = c[31-b];
      push_field({16'h0, r[7:0], r[15:8], r[23:16], r[31:24]}, 4);
    end
`endif
  endtask

  function automatic int first_mismatch(input logic [7:0] a[$], input int base, input logic [7:0] b[$]);
    if (a.size() < base + b.size()) return base + a.size();
    for (int i = 0; i < b.size(); i++) if (a[base+i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic logic [47:0] rx_bytes(input int base, input int n);
    logic [47:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[39:0], rx[base+i]};
    return r;
  endfunction

  initial begin
    int e0, f0, n;
    logic [47:0] m;
    logic [31:0] ip, rip;
    bit req;

    areset = 1'b1; mac_d_addr_in = '0; ip_d_addr_in = '0; rq_ip_addr = '0;
    arp_resp_start = 1'b0; arp_rq_start = 1'b0; m_axis_tready = 1'b1;

    // Reset state, during reset and on the cycle after release.
    step(); step();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 8'h00);
    check("rst_resp_end", arp_resp_end, 1'b0);
    areset = 1'b0;
    check("rst_after_tvalid", m_axis_tvalid, 1'b0);
    step(); step();
    check("idle_tvalid", m_axis_tvalid, 1'b0);

    // Directed reply, inputs scrambled after the latch edge.
    rx.delete(); e0 = resp_ends; f0 = frames;
    mac_d_addr_in = 48'h0A1B_2C3D_4E5F; ip_d_addr_in = 32'hC0A8_0002;
    arp_resp_start = 1'b1;
    step();
    check("reply_tvalid_next", m_axis_tvalid, 1'b1);
    mac_d_addr_in = 48'h1234_5678_9ABC; ip_d_addr_in = 32'hDEAD_BEEF;
    wait_frames(f0 + 1, 300);
    build_expected(0, 48'h0A1B_2C3D_4E5F, 32'hC0A8_0002);
    check("reply_len", rx.size(), FLEN);
    check("reply_frames", frames - f0, 1);
    check("reply_resp_end", resp_ends - e0, 1);
    check("reply_da", rx_bytes(0, 6), 48'h0A1B_2C3D_4E5F);
    check("reply_oper", rx_bytes(20, 2), 48'h0002);
    check("reply_model", first_mismatch(rx, 0, exp_q), -1);
`ifdef ARP_TX_FCS_EN
    check("fcs_residue", crc_run(rx, 64), 32'hC704_DD7B);
`endif
    ref_q = rx;

    // Directed request.
    rx.delete(); e0 = resp_ends; f0 = frames;
    rq_ip_addr = 32'hC0A8_00FE;
    arp_rq_start = 1'b1;
    step();
    arp_rq_start = 1'b0;
    step(); step();
    rq_ip_addr = 32'h0101_0101;
    wait_frames(f0 + 1, 300);
    build_expected(1, 48'h0, 32'hC0A8_00FE);
    check("req_len", rx.size(), FLEN);
    check("req_da", rx_bytes(0, 6), 48'hFFFF_FFFF_FFFF);
    check("req_oper", rx_bytes(20, 2), 48'h0001);
    check("req_tha", rx_bytes(32, 6), 48'h0);
    check("req_tpa", rx_bytes(38, 4), 48'hC0A8_00FE);
    check("req_no_resp_end", resp_ends - e0, 0);
    check("req_model", first_mismatch(rx, 0, exp_q), -1);

    // Backpressure: same reply with random tready must match the first run.
    rx.delete(); f0 = frames;
    mac_d_addr_in = 48'h0A1B_2C3D_4E5F; ip_d_addr_in = 32'hC0A8_0002;
    bp_en = 1; arp_resp_start = 1'b1;
    wait_frames(f0 + 1, 1000);
    bp_en = 0; m_axis_tready = 1'b1;
    check("bp_len", rx.size(), FLEN);
    check("bp_same_stream", first_mismatch(rx, 0, ref_q), -1);

    // Collision: request pulse mid-reply is served right after the reply.
    rx.delete(); e0 = resp_ends; f0 = frames;
    m = {$urandom, $urandom}; ip = $urandom; rip = $urandom;
    mac_d_addr_in = m; ip_d_addr_in = ip; rq_ip_addr = rip;
    arp_resp_start = 1'b1;
    for (int i = 0; i < 300 && rx.size() < 10; i++) step();
    arp_rq_start = 1'b1;
    step();
    arp_rq_start = 1'b0;
    for (int i = 0; i < 300 && !arp_resp_end; i++) step();
    check("col_resp_end_seen", arp_resp_end, 1'b1);
    n = 0;
    while (!m_axis_tvalid && n < 10) begin step(); n++; end
    check("col_gap", n, 2);
    wait_frames(f0 + 2, 300);
    check("col_len", rx.size(), 2 * FLEN);
    check("col_resp_end", resp_ends - e0, 1);
    build_expected(0, m, ip);
    check("col_reply", first_mismatch(rx, 0, exp_q), -1);
    build_expected(1, m, rip);
    check("col_request", first_mismatch(rx, FLEN, exp_q), -1);

    // Reset at byte 30 aborts the frame; the next one restarts at byte 0.
    rx.delete();
    m = {$urandom, $urandom}; ip = $urandom;
    mac_d_addr_in = m; ip_d_addr_in = ip;
    arp_resp_start = 1'b1;
    for (int i = 0; i < 300 && rx.size() < 30; i++) step();
    check("abort_reached_30", rx.size(), 30);
    areset = 1'b1;
    step();
    check("abort_rst_tvalid", m_axis_tvalid, 1'b0);
    rx.delete(); f0 = frames;
    step();
    areset = 1'b0;
    check("abort_after_tvalid", m_axis_tvalid, 1'b0);
    check("abort_after_tdata", m_axis_tdata, 8'h00);
    wait_frames(f0 + 1, 300);
    build_expected(0, m, ip);
    check("abort_len", rx.size(), FLEN);
    check("abort_da", rx_bytes(0, 6), m);
    check("abort_model", first_mismatch(rx, 0, exp_q), -1);

    // Randomized frames, with and without backpressure.
    for (int t = 0; t < 6; t++) begin
      rx.delete(); e0 = resp_ends; f0 = frames;
      req = 1'($urandom_range(0, 1));
      m = {$urandom, $urandom}; ip = $urandom; rip = $urandom;
      mac_d_addr_in = m; ip_d_addr_in = ip; rq_ip_addr = rip;
      bp_en = 1'($urandom_range(0, 1));
      if (req) begin
        arp_rq_start = 1'b1; step(); arp_rq_start = 1'b0;
      end else begin
        arp_resp_start = 1'b1;
      end
      wait_frames(f0 + 1, 1000);
      bp_en = 0; m_axis_tready = 1'b1;
      build_expected(req, m, req ? rip : ip);
      check("rand_len", rx.size(), FLEN);
      check("rand_resp_end", resp_ends - e0, !req);
      check("rand_model", first_mismatch(rx, 0, exp_q), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
